// File: rtl/rv32i_lsu.sv
// rv32i_lsu: load/store unit in front of the rv32i data RAM.
// Takes one load/store at a time, checks it, drives the RAM for one cycle,
// formats the byte-reversed RAM word into little-endian load data and holds
// a single response until the consumer accepts it.

`ifndef MEM_READ
`define MEM_READ       2'b00
`endif
`ifndef MEM_WRITE_WORD
`define MEM_WRITE_WORD 2'b01
`endif
`ifndef MEM_WRITE_HALF
`define MEM_WRITE_HALF 2'b10
`endif
`ifndef MEM_WRITE_BYTE
`define MEM_WRITE_BYTE 2'b11
`endif

module rv32i_lsu #(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_store,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_base,
  input  logic [11:0]           req_offset,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_illegal,
  output logic                  resp_misaligned,
  output logic                  resp_range,
  output logic [1:0]            mem_mode,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_value,
  input  logic [31:0]           mem_value
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic        op_store;
  logic [2:0]  op_funct3;
  logic [31:0] ea;
  logic        is_illegal;
  logic        is_misaligned;
  logic        is_range;
  logic        is_fault;
  logic [1:0]  write_code;
  logic [31:0] load_data;

  assign ea        = req_base + {{20{req_offset[11]}}, req_offset};
  assign req_ready = (state == IDLE);

  // Fault classification of the incoming request and its RAM write code
  always_comb begin
    is_illegal    = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                    (req_funct3 == 3'b111) || (req_store && req_funct3[2]);
    is_misaligned = ((req_funct3[1:0] == 2'b01) && ea[0]) ||
                    ((req_funct3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
    is_range      = (ea[31:ADDR_WIDTH] != '0);
    is_fault      = is_illegal || is_misaligned || is_range;
    case (req_funct3[1:0])
      2'b00:   write_code = `MEM_WRITE_BYTE;
      2'b01:   write_code = `MEM_WRITE_HALF;
      default: write_code = `MEM_WRITE_WORD;
    endcase
  end

  // Undo the RAM's byte reversal and apply sign or zero extension
  always_comb begin
    load_data = {mem_value[7:0], mem_value[15:8], mem_value[23:16], mem_value[31:24]};
    case (op_funct3)
      3'b000:  load_data = {{24{mem_value[31]}}, mem_value[31:24]};
      3'b100:  load_data = {24'h0, mem_value[31:24]};
      3'b001:  load_data = {{16{mem_value[23]}}, mem_value[23:16], mem_value[31:24]};
      3'b101:  load_data = {16'h0, mem_value[23:16], mem_value[31:24]};
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: faults skip the RAM entirely
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid) state_next = is_fault ? RESP : ISSUE;
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latching, single-cycle RAM drive and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_store        <= 1'b0;
      op_funct3       <= 3'b000;
      mem_mode        <= `MEM_READ;
      mem_address     <= '0;
      mem_write_value <= 32'h0;
      resp_valid      <= 1'b0;
      resp_rdata      <= 32'h0;
      resp_illegal    <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_range      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            op_store        <= req_store;
            op_funct3       <= req_funct3;
            resp_rdata      <= 32'h0;
            resp_illegal    <= is_illegal;
            resp_misaligned <= !is_illegal && is_misaligned;
            resp_range      <= !is_illegal && !is_misaligned && is_range;
            if (is_fault) begin
              resp_valid <= 1'b1;
            end else begin
              mem_address <= ea[ADDR_WIDTH-1:0];
              if (req_store) begin
                mem_mode        <= write_code;
                mem_write_value <= req_wdata;
              end else begin
                mem_mode <= `MEM_READ;
              end
            end
          end
        end
        ISSUE: begin
          mem_mode <= `MEM_READ;
        end
        CAPTURE: begin
          resp_rdata <= op_store ? 32'h0 : load_data;
          resp_valid <= 1'b1;
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_lsu.sv
// tb_rv32i_lsu: self-checking bench for rv32i_lsu with a behavioural data RAM,
// a directed vector table, multi-cycle corner sequences and a random run
// checked against a byte-array reference model.

`ifndef MEM_READ
`define MEM_READ       2'b00
`endif
`ifndef MEM_WRITE_WORD
`define MEM_WRITE_WORD 2'b01
`endif
`ifndef MEM_WRITE_HALF
`define MEM_WRITE_HALF 2'b10
`endif
`ifndef MEM_WRITE_BYTE
`define MEM_WRITE_BYTE 2'b11
`endif

module tb_rv32i_lsu;

  localparam int AW      = 5;
  localparam int MEMSIZE = 32;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_store;
  logic [2:0]    req_funct3;
  logic [31:0]   req_base;
  logic [11:0]   req_offset;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_illegal;
  logic          resp_misaligned;
  logic          resp_range;
  logic [1:0]    mem_mode;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_write_value;
  logic [31:0]   mem_value;

  typedef struct {
    logic        store;
    logic [2:0]  f3;
    logic [31:0] base;
    logic [11:0] off;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic [2:0]  expFlags;
    int          expLat;
    int          expWrites;
  } vec_t;

  int checks;
  int errors;
  int writeCycles;

  logic [7:0] ram    [MEMSIZE];
  logic [7:0] refMem [MEMSIZE];

  rv32i_lsu #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_base(req_base), .req_offset(req_offset),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_illegal(resp_illegal), .resp_misaligned(resp_misaligned),
    .resp_range(resp_range),
    .mem_mode(mem_mode), .mem_address(mem_address),
    .mem_write_value(mem_write_value), .mem_value(mem_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data RAM: byte-reversed registered read, LSB-first writes
  always @(posedge clk) begin
    logic [AW-1:0] a0, a1, a2, a3;
    a0 = mem_address;
    a1 = a0 + 1'b1;
    a2 = a0 + 2'd2;
    a3 = a0 + 2'd3;
    mem_value <= {ram[a0], ram[a1], ram[a2], ram[a3]};
    if (mem_mode != `MEM_READ) writeCycles++;
    case (mem_mode)
      `MEM_WRITE_WORD: begin
        ram[a0] <= mem_write_value[7:0];
        ram[a1] <= mem_write_value[15:8];
        ram[a2] <= mem_write_value[23:16];
        ram[a3] <= mem_write_value[31:24];
      end
      `MEM_WRITE_HALF: begin
        ram[a0] <= mem_write_value[7:0];
        ram[a1] <= mem_write_value[15:8];
      end
      `MEM_WRITE_BYTE: ram[a0] <= mem_write_value[7:0];
      default: ;
    endcase
  end

  // Runaway guard
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference model: byte-array memory with little-endian loads and stores
  task automatic refModel(input logic store, input logic [2:0] f3, input logic [31:0] base,
                          input logic [11:0] off, input logic [31:0] wdata,
                          output logic [31:0] expRdata, output logic [2:0] expFlags,
                          output int expLat, output int expWrites);
    logic [31:0] ea;
    logic [31:0] val;
    int size;
    logic ill, mis, rng;
    ea   = base + 32'($signed(off));
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill  = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) || (store && f3 >= 3'd4);
    mis  = (ea % size) != 0;
    rng  = ea >= MEMSIZE;
    expRdata  = 32'h0;
    expWrites = 0;
    if (ill)      expFlags = 3'b100;
    else if (mis) expFlags = 3'b010;
    else if (rng) expFlags = 3'b001;
    else          expFlags = 3'b000;
    expLat = (expFlags != 3'b000) ? 1 : 3;
    if (expFlags == 3'b000) begin
      if (store) begin
        for (int i = 0; i < size; i++) refMem[int'(ea) + i] = wdata[8*i +: 8];
        expWrites = 1;
      end else begin
        val = 32'h0;
        for (int i = 0; i < size; i++) val = val | (32'(refMem[int'(ea) + i]) << (8*i));
        if (!f3[2] && size < 4 && val[8*size-1])
          val = val | ~((32'h1 << (8*size)) - 32'h1);
        expRdata = val;
      end
    end
  endtask

  // One complete request/response exchange with immediate acceptance
  task automatic doTransaction(input logic store, input logic [2:0] f3, input logic [31:0] base,
                               input logic [11:0] off, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic [2:0] flags,
                               output int lat, output int writes);
    int w0;
    int waitCnt;
    waitCnt = 0;
    @(negedge clk);
    while (!req_ready && waitCnt < 10) begin
      @(negedge clk);
      waitCnt++;
    end
    req_store  = store;
    req_funct3 = f3;
    req_base   = base;
    req_offset = off;
    req_wdata  = wdata;
    req_valid  = 1'b1;
    w0 = writeCycles;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    rdata = resp_rdata;
    flags = {resp_illegal, resp_misaligned, resp_range};
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    writes = writeCycles - w0;
  endtask

  task automatic applyStimulus(input vec_t v, input bit useModel, input string tag);
    logic [31:0] mRd, rd;
    logic [2:0]  mFl, fl;
    int mLat, mWr, lat, wr;
    refModel(v.store, v.f3, v.base, v.off, v.wdata, mRd, mFl, mLat, mWr);
    if (useModel) begin
      v.expRdata  = mRd;
      v.expFlags  = mFl;
      v.expLat    = mLat;
      v.expWrites = mWr;
    end
    doTransaction(v.store, v.f3, v.base, v.off, v.wdata, rd, fl, lat, wr);
    checkOutput({tag, " rdata"},  rd, v.expRdata);
    checkOutput({tag, " flags"},  32'(fl), 32'(v.expFlags));
    checkOutput({tag, " latency"}, 32'(lat), 32'(v.expLat));
    checkOutput({tag, " writes"}, 32'(wr), 32'(v.expWrites));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " req_ready"},       32'(req_ready), 32'd1);
    checkOutput({tag, " resp_valid"},      32'(resp_valid), 32'd0);
    checkOutput({tag, " resp_rdata"},      resp_rdata, 32'h0);
    checkOutput({tag, " flags"},           32'({resp_illegal, resp_misaligned, resp_range}), 32'd0);
    checkOutput({tag, " mem_mode"},        32'(mem_mode), 32'(`MEM_READ));
    checkOutput({tag, " mem_address"},     32'(mem_address), 32'd0);
    checkOutput({tag, " mem_write_value"}, mem_write_value, 32'h0);
  endtask

  vec_t tbl [17];
  vec_t post [2];

  initial begin
    vec_t v;
    int w0;
    int sawValid;
    checks      = 0;
    errors      = 0;
    writeCycles = 0;
    for (int i = 0; i < MEMSIZE; i++) begin
      ram[i]    = 8'h0;
      refMem[i] = 8'h0;
    end

    //            st    f3      base     off     wdata         rdata         flags lat wr
    tbl[0]  = '{1'b1, 3'b010, 32'h10, 12'h000, 32'h80FF1234, 32'h00000000, 3'b000, 3, 1};
    tbl[1]  = '{1'b0, 3'b010, 32'h10, 12'h000, 32'h0,        32'h80FF1234, 3'b000, 3, 0};
    tbl[2]  = '{1'b0, 3'b000, 32'h13, 12'h000, 32'h0,        32'hFFFFFF80, 3'b000, 3, 0};
    tbl[3]  = '{1'b0, 3'b100, 32'h13, 12'h000, 32'h0,        32'h00000080, 3'b000, 3, 0};
    tbl[4]  = '{1'b0, 3'b001, 32'h12, 12'h000, 32'h0,        32'hFFFF80FF, 3'b000, 3, 0};
    tbl[5]  = '{1'b0, 3'b101, 32'h10, 12'h000, 32'h0,        32'h00001234, 3'b000, 3, 0};
    tbl[6]  = '{1'b1, 3'b000, 32'h04, 12'hFFF, 32'h000000AB, 32'h00000000, 3'b000, 3, 1};
    tbl[7]  = '{1'b0, 3'b010, 32'h00, 12'h000, 32'h0,        32'hAB000000, 3'b000, 3, 0};
    tbl[8]  = '{1'b0, 3'b001, 32'h05, 12'h000, 32'h0,        32'h00000000, 3'b010, 1, 0};
    tbl[9]  = '{1'b1, 3'b010, 32'h22, 12'h000, 32'h55555555, 32'h00000000, 3'b010, 1, 0};
    tbl[10] = '{1'b0, 3'b010, 32'h20, 12'h000, 32'h0,        32'h00000000, 3'b001, 1, 0};
    tbl[11] = '{1'b0, 3'b011, 32'h10, 12'h000, 32'h0,        32'h00000000, 3'b100, 1, 0};
    tbl[12] = '{1'b1, 3'b100, 32'h10, 12'h000, 32'hFFFFFFFF, 32'h00000000, 3'b100, 1, 0};
    tbl[13] = '{1'b0, 3'b010, 32'h10, 12'h000, 32'h0,        32'h80FF1234, 3'b000, 3, 0};
    tbl[14] = '{1'b1, 3'b010, 32'h20, 12'hFFC, 32'h11223344, 32'h00000000, 3'b000, 3, 1};
    tbl[15] = '{1'b1, 3'b001, 32'h1E, 12'h000, 32'h0000BEEF, 32'h00000000, 3'b000, 3, 1};
    tbl[16] = '{1'b0, 3'b010, 32'h1C, 12'h000, 32'h0,        32'hBEEF3344, 3'b000, 3, 0};
    post[0] = '{1'b1, 3'b010, 32'h1C, 12'h000, 32'hCAFEF00D, 32'h00000000, 3'b000, 3, 1};
    post[1] = '{1'b0, 3'b010, 32'h1C, 12'h000, 32'h0,        32'hCAFEF00D, 3'b000, 3, 0};

    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_base   = 32'h0;
    req_offset = 12'h0;
    req_wdata  = 32'h0;
    resp_ready = 1'b0;
    rst_n      = 1'b0;
    #12;
    checkResetState("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) applyStimulus(tbl[i], 1'b0, $sformatf("vec%0d", i));

    // Backpressure: response must hold and a new request must be ignored
    @(negedge clk);
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_base   = 32'h10;
    req_offset = 12'h0;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    sawValid = 0;
    for (int i = 0; i < 8 && sawValid == 0; i++) begin
      @(negedge clk);
      if (resp_valid) sawValid = 1;
    end
    checkOutput("bp response arrives", 32'(sawValid), 32'd1);
    w0 = writeCycles;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("bp hold%0d resp_valid", i), 32'(resp_valid), 32'd1);
      checkOutput($sformatf("bp hold%0d rdata", i), resp_rdata, 32'h80FF1234);
      checkOutput($sformatf("bp hold%0d req_ready", i), 32'(req_ready), 32'd0);
      if (i == 0) begin
        req_store  = 1'b1;
        req_funct3 = 3'b010;
        req_base   = 32'h10;
        req_wdata  = 32'hDEADBEEF;
        req_valid  = 1'b1;
      end
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    checkOutput("bp release req_ready", 32'(req_ready), 32'd1);
    checkOutput("bp release resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("bp ignored writes", 32'(writeCycles - w0), 32'd0);
    applyStimulus(tbl[13], 1'b0, "bp reread");

    // Asynchronous reset while a load is in ISSUE
    @(negedge clk);
    req_store  = 1'b0;
    req_funct3 = 3'b010;
    req_base   = 32'h1C;
    req_offset = 12'h0;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkResetState("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sawValid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (resp_valid) sawValid = 1;
    end
    checkOutput("midreset no response", 32'(sawValid), 32'd0);
    applyStimulus(post[0], 1'b0, "post SW");
    applyStimulus(post[1], 1'b0, "post LW");

    // Randomized traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      v.store = 1'($urandom_range(0, 1));
      v.f3    = 3'($urandom_range(0, 7));
      v.base  = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 36));
      v.off   = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 8) - 4);
      v.wdata = $urandom;
      v.expRdata  = 32'h0;
      v.expFlags  = 3'b000;
      v.expLat    = 0;
      v.expWrites = 0;
      applyStimulus(v, 1'b1, $sformatf("rand%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
